// File: rtl/dcache_snoop_responder_if.sv
// Snoop bus between the coherence controller and a dcache responder, plus the
// responder's view of the cache frame array.
interface dcache_snoop_responder_if;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        cctrans;
    logic        ccwrite;
    logic [31:0] ccdata;
    logic        ccdata_valid;
    logic        ccdata_ready;
    logic [2:0]  frame_idx;
    logic [25:0] frame_tag;
    logic        frame_valid;
    logic        frame_dirty;
    logic [31:0] frame_data1;
    logic [31:0] frame_data2;
    logic        frame_inv;
    logic        frame_clean;
    logic        core_hold;

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, ccdata_ready,
               frame_tag, frame_valid, frame_dirty, frame_data1, frame_data2,
        output cctrans, ccwrite, ccdata, ccdata_valid,
               frame_idx, frame_inv, frame_clean, core_hold
    );

    modport master (
        output ccwait, ccinv, ccsnoopaddr, ccdata_ready,
               frame_tag, frame_valid, frame_dirty, frame_data1, frame_data2,
        input  cctrans, ccwrite, ccdata, ccdata_valid,
               frame_idx, frame_inv, frame_clean, core_hold
    );
endinterface

// File: rtl/dcache_snoop_responder.sv
// Dcache snoop responder: looks up a snooped frame, reports hit/dirty, supplies
// the two-word block on a dirty hit, then invalidates or cleans the frame.
module dcache_snoop_responder (
    input  logic                     CLK,
    input  logic                     nRST,
    dcache_snoop_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_RESP   = 3'd2,
        S_WORD1  = 3'd3,
        S_WORD2  = 3'd4,
        S_UPDATE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_saddr;
    logic        r_sinv;
    logic        r_hit;
    logic        r_dirty;
    logic [31:0] r_w1;
    logic [31:0] r_w2;
    logic        w_abort;
    logic        w_unused_offset;

    assign w_abort         = ~bus.ccwait;
    assign w_unused_offset = ^r_saddr[2:0];

    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Dropping ccwait before the update phase abandons the snoop untouched.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.ccwait) w_next = S_LOOKUP;
            S_LOOKUP: w_next = w_abort ? S_IDLE : S_RESP;
            S_RESP: begin
                if (w_abort)                 w_next = S_IDLE;
                else if (r_hit && r_dirty)   w_next = S_WORD1;
                else if (r_hit && r_sinv)    w_next = S_UPDATE;
                else                         w_next = S_DONE;
            end
            S_WORD1: begin
                if (w_abort)               w_next = S_IDLE;
                else if (bus.ccdata_ready) w_next = S_WORD2;
            end
            S_WORD2: begin
                if (w_abort)               w_next = S_IDLE;
                else if (bus.ccdata_ready) w_next = S_UPDATE;
            end
            S_UPDATE: w_next = S_DONE;
            S_DONE:   if (!bus.ccwait) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_saddr <= 32'h0;
            r_sinv  <= 1'b0;
            r_hit   <= 1'b0;
            r_dirty <= 1'b0;
            r_w1    <= 32'h0;
            r_w2    <= 32'h0;
        end else begin
            if (r_state == S_IDLE && bus.ccwait) begin
                r_saddr <= bus.ccsnoopaddr;
                r_sinv  <= bus.ccinv;
            end
            if (r_state == S_LOOKUP) begin
                r_hit   <= bus.frame_valid && (bus.frame_tag == r_saddr[31:6]);
                r_dirty <= bus.frame_dirty;
                r_w1    <= bus.frame_data1;
                r_w2    <= bus.frame_data2;
            end
        end
    end

    always_comb begin
        bus.cctrans      = 1'b0;
        bus.ccwrite      = 1'b0;
        bus.ccdata       = 32'h0;
        bus.ccdata_valid = 1'b0;
        bus.frame_inv    = 1'b0;
        bus.frame_clean  = 1'b0;
        case (r_state)
            S_RESP: begin
                bus.cctrans = 1'b1;
                bus.ccwrite = r_hit & r_dirty;
            end
            S_WORD1: begin
                bus.ccdata       = r_w1;
                bus.ccdata_valid = 1'b1;
            end
            S_WORD2: begin
                bus.ccdata       = r_w2;
                bus.ccdata_valid = 1'b1;
            end
            S_UPDATE: begin
                bus.frame_inv   = r_sinv;
                bus.frame_clean = ~r_sinv & r_dirty;
            end
            default: ;
        endcase
    end

    // Hold must rise combinationally with ccwait so the core freezes at once.
    assign bus.core_hold = bus.ccwait | (r_state != S_IDLE);
    assign bus.frame_idx = r_saddr[5:3];
endmodule

// File: doc/dcache_snoop_responder.md
# dcache_snoop_responder

Responder side of the coherence bus snoop protocol. Sits inside each core's dcache, receives snoop requests issued by the bus controller's SNOOPING phases, looks up the addressed frame, reports hit/dirty status, supplies the two-word block on a dirty hit (the cache's CCWB1/CCWB2 path), then invalidates or cleans the frame. Stalls the local dcache FSM for the duration of a snoop.

## Interface
- No parameters; geometry is fixed: 8 direct-mapped frames, address split tag[31:6], index[5:3], block offset[2], byte[1:0].
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous, active-low reset.
- ccwait  in  1  snoop request from bus controller; held high until the snoop is finished.
- ccinv  in  1  snoop is invalidating (remote write miss); valid while ccwait high.
- ccsnoopaddr  in  32  snooped address; valid while ccwait high.
- cctrans  out  1  one-cycle pulse: lookup result valid.
- ccwrite  out  1  valid with cctrans: 1 = dirty hit, block will be supplied.
- ccdata  out  32  supplied data word.
- ccdata_valid  out  1  ccdata valid.
- ccdata_ready  in  1  bus accepts ccdata this cycle.
- frame_idx  out  3  frame index for combinational cache-array read.
- frame_tag  in  26  tag of indexed frame.
- frame_valid, frame_dirty  in  1 each  status of indexed frame.
- frame_data1, frame_data2  in  32 each  word 0 / word 1 of indexed frame.
- frame_inv  out  1  one-cycle strobe: clear valid and dirty of frame_idx.
- frame_clean  out  1  one-cycle strobe: clear dirty of frame_idx.
- core_hold  out  1  dcache FSM must freeze and not touch arrays.

## Operation
- Registers: state, saddr[31:0], sinv, hit, dirty, w1[31:0], w2[31:0].
- frame_idx = saddr[5:3] at all times; saddr resets to 0.
- core_hold = ccwait | (state != IDLE), combinational, so the dcache freezes the same cycle ccwait rises.
- IDLE: if ccwait, latch saddr<=ccsnoopaddr, sinv<=ccinv, go LOOKUP.
- LOOKUP: hit <= frame_valid & (frame_tag == saddr[31:6]); dirty <= frame_dirty; w1<=frame_data1; w2<=frame_data2; go RESP.
- RESP: cctrans=1, ccwrite=hit&dirty. Next: hit&dirty -> WORD1; hit&~dirty&sinv -> UPDATE; else -> DONE.
- WORD1: ccdata=w1, ccdata_valid=1; ccdata_ready -> WORD2.
- WORD2: ccdata=w2, ccdata_valid=1; ccdata_ready -> UPDATE.
- UPDATE (one cycle): frame_inv=sinv; frame_clean=~sinv & dirty. Go DONE.
- DONE: all outputs 0 except core_hold; when ccwait low -> IDLE.
- Abort: ccwait low in LOOKUP, RESP, WORD1 or WORD2 -> IDLE next cycle, no cctrans after abort cycle, no frame_inv/frame_clean. ccwait low in UPDATE: update still completes, then DONE -> IDLE.
- ccinv and ccsnoopaddr changes after IDLE are ignored (latched values used).
- Word order fixed: word 0 (offset 0) then word 1, regardless of saddr[2].
- ccdata = 0 whenever ccdata_valid = 0.

## Timing
- Reset: state=IDLE; cctrans, ccwrite, ccdata_valid, frame_inv, frame_clean = 0; ccdata = 0; frame_idx = 0; core_hold = ccwait.
- ccwait first sampled high at edge 0: LOOKUP cycle 1, cctrans pulse cycle 2, first ccdata_valid cycle 3.
- Miss or clean non-invalidating hit: DONE at cycle 3.
- Clean invalidating hit: frame_inv cycle 3.
- Dirty hit with ccdata_ready always high: word 0 cycle 3, word 1 cycle 4, strobe cycle 5, DONE cycle 6.
- Each cycle of ccdata_ready low extends the current word by one cycle; ccdata held stable.
- Back-to-back snoops: minimum one IDLE cycle between DONE and next LOOKUP.

## Test plan
- Miss: frame 2 invalid, ccwait=1, ccsnoopaddr=0x0000_0050 -> cctrans cycle 2 with ccwrite=0, no ccdata_valid, no strobes, core_hold high until ccwait drops.
- Clean hit, ccinv=1: frame 2 tag 0x1, valid, clean, addr 0x0000_0050 -> ccwrite=0, frame_inv=1 cycle 3, frame_idx=2.
- Dirty hit read, ccinv=0: data1=0xDEAD_BEEF, data2=0xCAFE_F00D, ccdata_ready low for 2 cycles then high -> 0xDEAD_BEEF held cycles 3-5, 0xCAFE_F00D cycle 6, frame_clean=1 cycle 7, frame_inv=0.
- Dirty hit, ccinv=1, ready always high -> words cycles 3-4, frame_inv cycle 5, frame_clean=0.
- Abort: dirty hit, ccwait dropped during WORD2 -> IDLE next cycle, no strobes, core_hold low once ccwait low and state IDLE.
- nRST low during WORD1 -> next cycle all outputs 0, state IDLE; a new snoop afterwards completes normally.
